mem_sum_ctrl: RTL and testbench
===============================

MEM_SUM_CTRL -- requirements
Module: mem_sum_ctrl

Interface
REQ-001 Parameter: CNT_W, 8, width of the word-count input; max run length 2^CNT_W-1 words.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: start  input  1  request to begin one summation run; sampled on clk rising edge.
REQ-005 Port: base_addr  input  32  word address of first operand; sampled when start accepted.
REQ-006 Port: count  input  CNT_W  number of consecutive words to sum; sampled when start accepted.
REQ-007 Port: dest_addr  input  32  word address receiving the sum; sampled when start accepted.
REQ-008 Port: mem_addr  output  32  address driven to the data memory.
REQ-009 Port: mem_wdata  output  32  write data driven to the data memory.
REQ-010 Port: mem_read  output  1  memory read strobe.
REQ-011 Port: mem_write  output  1  memory write strobe.
REQ-012 Port: mem_rdata  input  32  memory read data, combinationally valid in the same cycle as mem_addr/mem_read.
REQ-013 Port: busy  output  1  high from the cycle after start acceptance through the WRITE state.
REQ-014 Port: done  output  1  one-cycle pulse after the result write completes.
REQ-015 Port: result  output  32  last computed sum; held until the next run's DONE.

Function
REQ-016 FSM states SHALL be IDLE, READ, WRITE, DONE; all outputs registered or decoded from registered state only.
REQ-017 IDLE: start=1 at a clock edge SHALL latch base_addr, count, dest_addr, clear accumulator and index, go to READ (count>0) or WRITE (count=0).
REQ-018 READ: mem_read=1, mem_write=0, mem_addr=latched base+index; at each edge accumulator += mem_rdata, index += 1.
REQ-019 READ SHALL last exactly count cycles, then go to WRITE.
REQ-020 WRITE: mem_write=1, mem_read=0, mem_addr=dest, mem_wdata=accumulator, exactly one cycle, then DONE.
REQ-021 DONE: done=1, busy=0, result updated to accumulator at the WRITE->DONE edge; one cycle, then IDLE.
REQ-022 Latency: start edge to done high = count+2 cycles; count=0 gives 2 cycles and writes 0.
REQ-023 Accumulator and address arithmetic SHALL wrap modulo 2^32; no overflow flag.
REQ-024 mem_read and mem_write SHALL never be high in the same cycle; both 0 in IDLE and DONE.
REQ-025 In IDLE/DONE mem_addr and mem_wdata SHALL be 0.
REQ-026 start while busy or in DONE SHALL be ignored (no queueing, no input re-latch).
REQ-027 Inputs base_addr/count/dest_addr changing after acceptance SHALL not affect the run.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0, done=0, result=0, accumulator=0, index=0.
REQ-029 Reset mid-run SHALL abort with no memory write issued; first legal start is the first edge with rst=1.
REQ-030 start high during the release edge of rst SHALL not be accepted; acceptance begins the following edge.

Verification
REQ-031 Memory words 1000..1009 = 1..10, start with base=1000, count=10, dest=1010 -> 10 read cycles addr 1000..1009, one write of 55 to 1010, done at cycle 12, result=55.
REQ-032 count=0, dest=5 -> no read cycle, write of 0 to addr 5, done 2 cycles after start.
REQ-033 Words 0xFFFFFFFF, 0x00000002 at 20,21, count=2 -> written sum 0x00000001 (wrap).
REQ-034 Second start pulse during READ with different base -> ignored; first run result unchanged, only one done pulse.
REQ-035 rst asserted during 5th READ cycle of a count=10 run -> all outputs 0 same time, no mem_write pulse ever, result=0.
REQ-036 Every run: assert mem_read & mem_write never both 1; busy low exactly on done cycle and in IDLE.

Source files
------------

// File: rtl/mem_sum_ctrl.sv
// Memory summation controller: reads a run of consecutive words, accumulates
// their sum, writes it to a destination word and reports it on result.
module mem_sum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      dest_addr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state;
  logic [31:0]      dest;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [31:0]      sum_next;

  assign sum_next = acc + mem_rdata;

  // mem_addr doubles as the running base+index pointer during READ, so the
  // base address only needs to be captured once at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dest      <= '0;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dest <= dest_addr;
            cnt  <= count;
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
            if (count != '0) begin
              state    <= READ;
              mem_read <= 1'b1;
              mem_addr <= base_addr;
            end else begin
              state     <= WRITE;
              mem_write <= 1'b1;
              mem_addr  <= dest_addr;
              mem_wdata <= '0;
            end
          end
        end
        READ: begin
          acc <= sum_next;
          idx <= idx + CNT_W'(1);
          // On the last read the final word is folded straight into the write data.
          if (idx == cnt - CNT_W'(1)) begin
            state     <= WRITE;
            mem_read  <= 1'b0;
            mem_write <= 1'b1;
            mem_addr  <= dest;
            mem_wdata <= sum_next;
          end else begin
            mem_addr <= mem_addr + 32'd1;
          end
        end
        WRITE: begin
          state     <= DONE;
          mem_write <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
          result    <= acc;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sum_ctrl.sv
// Self-checking bench for mem_sum_ctrl: directed and random summation runs
// compared against a plain-arithmetic model over a bench-side memory array.
module tb_mem_sum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  count;
  logic [31:0] dest_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          done_cnt;
  int          vectors;
  int          miscompares;

  mem_sum_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .count(count), .dest_addr(dest_addr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:0]];

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records every read/write strobe and enforces the
  // read/write exclusion and busy rules on every cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_read) rd_q.push_back(mem_addr);
      if (mem_write) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end
      if (done) begin
        done_cnt++;
        check_output("busy_on_done", 32'(busy), 32'd0);
      end
      if (mem_read || mem_write) check_output("busy_in_run", 32'(busy), 32'd1);
      check_output("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    end
  end

  task automatic apply_stimulus(input logic [31:0] b, input logic [7:0] c,
                                input logic [31:0] d, input bit poke);
    logic [31:0] exp_sum;
    int          lat;
    bit          seen;
    exp_sum = 32'd0;
    for (int i = 0; i < int'(c); i++) exp_sum += mem[12'(b + 32'(i))];
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c; dest_addr = d;
    @(posedge clk);
    #1;
    start = 1'b0; base_addr = $urandom; count = 8'($urandom); dest_addr = $urandom;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < int'(c) + 10) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      if (poke && lat == 2) begin
        start = 1'b1;
        base_addr = b + 32'd100;
      end else begin
        start = 1'b0;
      end
    end
    check_output("done_seen", 32'(seen), 32'd1);
    check_output("latency", 32'(lat), 32'(int'(c) + 2));
    check_output("result", result, exp_sum);
    @(negedge clk);
    check_output("idle_done", 32'(done), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_addr", mem_addr, 32'd0);
    check_output("idle_wdata", mem_wdata, 32'd0);
    check_output("result_hold", result, exp_sum);
    repeat (3) @(negedge clk);
    check_output("done_pulses", 32'(done_cnt), 32'd1);
    check_output("read_cycles", 32'(rd_q.size()), 32'(c));
    for (int i = 0; i < rd_q.size(); i++)
      check_output("read_addr", rd_q[i], b + 32'(i));
    check_output("write_cycles", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check_output("write_addr", wa_q[0], d);
      check_output("write_data", wd_q[0], exp_sum);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    dest_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 10; i++) mem[1000 + i] = 32'(i + 1);
    mem[20] = 32'hFFFF_FFFF;
    mem[21] = 32'h0000_0002;

    repeat (2) @(negedge clk);
    check_output("rst_read", 32'(mem_read), 32'd0);
    check_output("rst_write", 32'(mem_write), 32'd0);
    check_output("rst_addr", mem_addr, 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_result", result, 32'd0);
    rst = 1'b1;

    $display("[TB] directed: ten-word sum");
    apply_stimulus(32'd1000, 8'd10, 32'd1010, 1'b0);
    $display("[TB] directed: zero count");
    apply_stimulus(32'd0, 8'd0, 32'd5, 1'b0);
    $display("[TB] directed: wrapping sum");
    apply_stimulus(32'd20, 8'd2, 32'd22, 1'b0);
    $display("[TB] directed: start ignored while busy");
    apply_stimulus(32'd1000, 8'd10, 32'd1010, 1'b1);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] b;
      logic [7:0]  c;
      logic [31:0] d;
      b = 32'($urandom_range(0, 3000));
      c = 8'($urandom_range(1, 40));
      d = 32'($urandom_range(3100, 4095));
      $display("[TB] random run %0d: base=%0d count=%0d dest=%0d", r, b, c, d);
      apply_stimulus(b, c, d, 1'b0);
    end

    $display("[TB] reset during fifth read cycle");
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'd1000; count = 8'd10; dest_addr = 32'd1010;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_read", 32'(mem_read), 32'd0);
    check_output("abort_write", 32'(mem_write), 32'd0);
    check_output("abort_addr", mem_addr, 32'd0);
    check_output("abort_wdata", mem_wdata, 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_output("abort_no_write", 32'(wa_q.size()), 32'd0);
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    check_output("abort_result_held", result, 32'd0);

    $display("[TB] run after reset recovery");
    apply_stimulus(32'd1000, 8'd10, 32'd1010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
